// File: rtl/tile_step_mover_if.sv
// ============================================================================
// Module   : tile_step_mover_if
// Brief    : Collision-query handshake between the mover and the tile store.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tile_step_mover_if #(
    parameter int MAP_W = 20,
    parameter int MAP_H = 15
);
    localparam int c_XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int c_YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

    logic            blk_req;
    logic [c_XW-1:0] blk_x;
    logic [c_YW-1:0] blk_y;
    logic            blk_ack;
    logic            blk_blocked;

    modport master (output blk_req, blk_x, blk_y, input  blk_ack, blk_blocked);
    modport slave  (input  blk_req, blk_x, blk_y, output blk_ack, blk_blocked);
endinterface

`default_nettype wire

// File: rtl/tile_step_mover.sv
// ============================================================================
// Module   : tile_step_mover
// Brief    : Grid-locked sprite mover with turn delay, collision query and
//            walk-cycle animation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tile_step_mover #(
    parameter int TILE_PX     = 16,
    parameter int MAP_W       = 20,
    parameter int MAP_H       = 15,
    parameter int STEP_PX     = 1,
    parameter int TURN_FRAMES = 2,
    parameter int ANIM_DIV    = 4,
    parameter int START_X     = 10,
    parameter int START_Y     = 7,
    localparam int c_XW = (MAP_W > 1) ? $clog2(MAP_W) : 1,
    localparam int c_YW = (MAP_H > 1) ? $clog2(MAP_H) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic [7:0]          keycode,
    tile_step_mover_if.master   blk,
    output logic [c_XW-1:0]     tile_x,
    output logic [c_YW-1:0]     tile_y,
    output logic [9:0]          pos_x,
    output logic [9:0]          pos_y,
    output logic [1:0]          direction,
    output logic                moving,
    output logic [1:0]          anim_frame,
    output logic                bump
);
    localparam int c_OW = $clog2(TILE_PX) + 1;
    localparam int c_TW = $clog2(TURN_FRAMES + 1) + 1;
    localparam int c_AW = $clog2(ANIM_DIV + 1) + 1;

    localparam logic [1:0] c_DIR_DOWN  = 2'd0;
    localparam logic [1:0] c_DIR_UP    = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_REQ, S_WALK} state_t;

    state_t          r_state,    w_state_nxt;
    logic [c_XW-1:0] r_tile_x,   w_tile_x_nxt;
    logic [c_YW-1:0] r_tile_y,   w_tile_y_nxt;
    logic [c_XW-1:0] r_blk_x,    w_blk_x_nxt;
    logic [c_YW-1:0] r_blk_y,    w_blk_y_nxt;
    logic            r_req,      w_req_nxt;
    logic [1:0]      r_dir,      w_dir_nxt;
    logic [c_OW-1:0] r_off,      w_off_nxt;
    logic [c_TW-1:0] r_turn_cnt, w_turn_cnt_nxt;
    logic [c_AW-1:0] r_anim_cnt, w_anim_cnt_nxt;
    logic [1:0]      r_anim,     w_anim_nxt;
    logic            r_bump,     w_bump_nxt;
    logic [9:0]      r_pos_x,    w_pos_x_nxt;
    logic [9:0]      r_pos_y,    w_pos_y_nxt;

    logic            w_key_vld;
    logic [1:0]      w_key_dir;
    logic            w_at_edge;
    logic [c_XW-1:0] w_tgt_x;
    logic [c_YW-1:0] w_tgt_y;
    logic [c_OW-1:0] w_off_inc;
    logic [c_TW-1:0] w_turn_inc;
    logic [c_AW-1:0] w_anim_inc;

    always_comb begin
        w_key_vld = 1'b1;
        w_key_dir = c_DIR_DOWN;
        case (keycode)
            8'h1A:   w_key_dir = c_DIR_UP;
            8'h16:   w_key_dir = c_DIR_DOWN;
            8'h04:   w_key_dir = c_DIR_LEFT;
            8'h07:   w_key_dir = c_DIR_RIGHT;
            default: w_key_vld = 1'b0;
        endcase
    end

    // Target is only consumed when the key matches the current facing.
    always_comb begin
        w_tgt_x   = r_tile_x;
        w_tgt_y   = r_tile_y;
        w_at_edge = 1'b0;
        case (r_dir)
            c_DIR_DOWN: begin
                w_at_edge = (int'(r_tile_y) >= MAP_H - 1);
                w_tgt_y   = r_tile_y + c_YW'(1);
            end
            c_DIR_UP: begin
                w_at_edge = (r_tile_y == '0);
                w_tgt_y   = r_tile_y - c_YW'(1);
            end
            c_DIR_LEFT: begin
                w_at_edge = (r_tile_x == '0);
                w_tgt_x   = r_tile_x - c_XW'(1);
            end
            default: begin
                w_at_edge = (int'(r_tile_x) >= MAP_W - 1);
                w_tgt_x   = r_tile_x + c_XW'(1);
            end
        endcase
    end

    assign w_off_inc  = r_off + c_OW'(STEP_PX);
    assign w_turn_inc = r_turn_cnt + c_TW'(1);
    assign w_anim_inc = r_anim_cnt + c_AW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_tile_x_nxt   = r_tile_x;
        w_tile_y_nxt   = r_tile_y;
        w_blk_x_nxt    = r_blk_x;
        w_blk_y_nxt    = r_blk_y;
        w_req_nxt      = r_req;
        w_dir_nxt      = r_dir;
        w_off_nxt      = r_off;
        w_turn_cnt_nxt = r_turn_cnt;
        w_anim_cnt_nxt = r_anim_cnt;
        w_anim_nxt     = r_anim;
        w_bump_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_tick) begin
                    if (!w_key_vld) begin
                        w_anim_nxt     = 2'd0;
                        w_anim_cnt_nxt = '0;
                    end else if (w_key_dir != r_dir) begin
                        w_dir_nxt      = w_key_dir;
                        w_turn_cnt_nxt = '0;
                        w_state_nxt    = S_TURN;
                    end else if (w_at_edge) begin
                        w_bump_nxt = 1'b1;
                    end else begin
                        w_blk_x_nxt = w_tgt_x;
                        w_blk_y_nxt = w_tgt_y;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_TURN: begin
                if (TURN_FRAMES == 0) begin
                    w_state_nxt = S_IDLE;
                end else if (frame_tick) begin
                    w_turn_cnt_nxt = w_turn_inc;
                    if (w_turn_inc == c_TW'(TURN_FRAMES))
                        w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (blk.blk_ack) begin
                    w_req_nxt = 1'b0;
                    if (blk.blk_blocked) begin
                        w_bump_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_off_nxt   = '0;
                        w_state_nxt = S_WALK;
                    end
                end
            end
            default: begin
                // The committing tick finishes the tile; the walk cycle only
                // advances on the in-between ticks.
                if (frame_tick) begin
                    if (w_off_inc >= c_OW'(TILE_PX)) begin
                        w_tile_x_nxt = r_blk_x;
                        w_tile_y_nxt = r_blk_y;
                        w_off_nxt    = '0;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_off_nxt = w_off_inc;
                        if (w_anim_inc >= c_AW'(ANIM_DIV)) begin
                            w_anim_nxt     = r_anim + 2'd1;
                            w_anim_cnt_nxt = '0;
                        end else begin
                            w_anim_cnt_nxt = w_anim_inc;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_pos_x_nxt = 10'(r_tile_x) * 10'(TILE_PX);
        w_pos_y_nxt = 10'(r_tile_y) * 10'(TILE_PX);
        case (r_dir)
            c_DIR_DOWN:  w_pos_y_nxt = w_pos_y_nxt + 10'(r_off);
            c_DIR_UP:    w_pos_y_nxt = w_pos_y_nxt - 10'(r_off);
            c_DIR_LEFT:  w_pos_x_nxt = w_pos_x_nxt - 10'(r_off);
            default:     w_pos_x_nxt = w_pos_x_nxt + 10'(r_off);
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_tile_x   <= c_XW'(START_X);
            r_tile_y   <= c_YW'(START_Y);
            r_blk_x    <= '0;
            r_blk_y    <= '0;
            r_req      <= 1'b0;
            r_dir      <= c_DIR_DOWN;
            r_off      <= '0;
            r_turn_cnt <= '0;
            r_anim_cnt <= '0;
            r_anim     <= 2'd0;
            r_bump     <= 1'b0;
            r_pos_x    <= 10'(START_X * TILE_PX);
            r_pos_y    <= 10'(START_Y * TILE_PX);
        end else begin
            r_state    <= w_state_nxt;
            r_tile_x   <= w_tile_x_nxt;
            r_tile_y   <= w_tile_y_nxt;
            r_blk_x    <= w_blk_x_nxt;
            r_blk_y    <= w_blk_y_nxt;
            r_req      <= w_req_nxt;
            r_dir      <= w_dir_nxt;
            r_off      <= w_off_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_anim_cnt <= w_anim_cnt_nxt;
            r_anim     <= w_anim_nxt;
            r_bump     <= w_bump_nxt;
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
        end
    end

    assign blk.blk_req = r_req;
    assign blk.blk_x   = r_blk_x;
    assign blk.blk_y   = r_blk_y;
    assign tile_x      = r_tile_x;
    assign tile_y      = r_tile_y;
    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign direction   = r_dir;
    assign moving      = (r_state == S_WALK);
    assign anim_frame  = r_anim;
    assign bump        = r_bump;
endmodule

`default_nettype wire

// File: tb/tb_tile_step_mover.sv
// ============================================================================
// Module   : tb_tile_step_mover
// Brief    : Self-checking bench for tile_step_mover against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tile_step_mover;
    localparam int TILE_PX = 16, MAP_W = 20, MAP_H = 15, STEP_PX = 1;
    localparam int TURN_FRAMES = 2, ANIM_DIV = 4, START_X = 10, START_Y = 7;
    localparam int MD_IDLE = 0, MD_TURN = 1, MD_REQ = 2, MD_WALK = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [4:0] tile_x;
    logic [3:0] tile_y;
    logic [9:0] pos_x, pos_y;
    logic [1:0] direction, anim_frame;
    logic       moving, bump;

    tile_step_mover_if #(.MAP_W(MAP_W), .MAP_H(MAP_H)) bif ();

    tile_step_mover #(
        .TILE_PX(TILE_PX), .MAP_W(MAP_W), .MAP_H(MAP_H), .STEP_PX(STEP_PX),
        .TURN_FRAMES(TURN_FRAMES), .ANIM_DIV(ANIM_DIV),
        .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
        .blk(bif), .tile_x(tile_x), .tile_y(tile_y), .pos_x(pos_x), .pos_y(pos_y),
        .direction(direction), .moving(moving), .anim_frame(anim_frame), .bump(bump)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: plain integers, one facing index per direction.
    int m_x, m_y, m_dir, m_off, m_anim, m_acnt, m_mode, m_turn, m_tx, m_ty, m_px, m_py;
    bit m_req, m_bump;
    int dx[4] = '{0, 0, -1, 1};
    int dy[4] = '{1, -1, 0, 0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h16:   return 0;
            8'h1A:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_dir = 0; m_off = 0; m_anim = 0; m_acnt = 0;
        m_mode = MD_IDLE; m_turn = 0; m_tx = 0; m_ty = 0; m_req = 0; m_bump = 0;
        m_px = (START_X * TILE_PX) & 1023;
        m_py = (START_Y * TILE_PX) & 1023;
    endtask

    task automatic model_step(input bit tick, input logic [7:0] key, input bit ack, input bit blkd);
        int kd, nx, ny, sx, sy;
        sx = (m_dir == 3) ? m_off : ((m_dir == 2) ? -m_off : 0);
        sy = (m_dir == 0) ? m_off : ((m_dir == 1) ? -m_off : 0);
        m_px = (m_x * TILE_PX + sx) & 1023;
        m_py = (m_y * TILE_PX + sy) & 1023;
        m_bump = 0;
        if (m_mode == MD_IDLE && tick) begin
            kd = key_dir(key);
            if (kd < 0) begin
                m_anim = 0; m_acnt = 0;
            end else if (kd != m_dir) begin
                m_dir = kd; m_turn = 0; m_mode = MD_TURN;
            end else begin
                nx = m_x + dx[m_dir];
                ny = m_y + dy[m_dir];
                if (nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H) m_bump = 1;
                else begin
                    m_tx = nx; m_ty = ny; m_req = 1; m_mode = MD_REQ;
                end
            end
        end else if (m_mode == MD_TURN) begin
            if (TURN_FRAMES == 0) m_mode = MD_IDLE;
            else if (tick) begin
                m_turn++;
                if (m_turn == TURN_FRAMES) m_mode = MD_IDLE;
            end
        end else if (m_mode == MD_REQ && ack) begin
            m_req = 0;
            if (blkd) begin m_bump = 1; m_mode = MD_IDLE; end
            else begin m_off = 0; m_mode = MD_WALK; end
        end else if (m_mode == MD_WALK && tick) begin
            if (m_off + STEP_PX >= TILE_PX) begin
                m_x = m_tx; m_y = m_ty; m_off = 0; m_mode = MD_IDLE;
            end else begin
                m_off += STEP_PX;
                m_acnt++;
                if (m_acnt == ANIM_DIV) begin m_anim = (m_anim + 1) % 4; m_acnt = 0; end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("tile_x", int'(tile_x), m_x);
        check_eq("tile_y", int'(tile_y), m_y);
        check_eq("pos_x", int'(pos_x), m_px);
        check_eq("pos_y", int'(pos_y), m_py);
        check_eq("direction", int'(direction), m_dir);
        check_eq("moving", int'(moving), (m_mode == MD_WALK) ? 1 : 0);
        check_eq("anim_frame", int'(anim_frame), m_anim);
        check_eq("bump", int'(bump), int'(m_bump));
        check_eq("blk_req", int'(bif.blk_req), int'(m_req));
        if (m_req) begin
            check_eq("blk_x", int'(bif.blk_x), m_tx);
            check_eq("blk_y", int'(bif.blk_y), m_ty);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge happen, then compare.
    task automatic cyc(input bit tick, input logic [7:0] key, input bit ack, input bit blkd);
        frame_tick = tick; keycode = key; bif.blk_ack = ack; bif.blk_blocked = blkd;
        @(posedge Clk);
        model_step(tick, key, ack, blkd);
        @(negedge Clk);
        compare_all();
    endtask

    // One frame tick followed by three quiet cycles; an outstanding query is
    // answered on the first quiet cycle.
    task automatic run_frames(input int n, input logic [7:0] key, input bit blkd);
        for (int f = 0; f < n; f++) begin
            cyc(1'b1, key, 1'b0, 1'b0);
            for (int c = 0; c < 3; c++) cyc(1'b0, key, m_req, blkd);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    logic [7:0] keys [6] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};
    logic [7:0] cur_key;
    bit         r_tick, r_ack, r_blk;

    initial begin
        bif.blk_ack = 1'b0;
        bif.blk_blocked = 1'b0;
        @(negedge Clk);
        do_reset();

        // Idle with no key stays parked at the start tile.
        run_frames(10, 8'h00, 1'b0);
        check_eq("idle_pos_x", int'(pos_x), 160);
        check_eq("idle_pos_y", int'(pos_y), 112);

        // Turn right, query, walk one tile.
        run_frames(3, 8'h07, 1'b0);
        check_eq("turn_dir", int'(direction), 3);
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        check_eq("req_x", int'(bif.blk_x), 11);
        check_eq("req_y", int'(bif.blk_y), 7);
        cyc(1'b0, 8'h07, 1'b1, 1'b0);
        run_frames(16, 8'h07, 1'b0);
        check_eq("step_tile_x", int'(tile_x), 11);
        check_eq("step_pos_x", int'(pos_x), 176);
        check_eq("step_anim", int'(anim_frame), 3);
        run_frames(1, 8'h00, 1'b0);
        check_eq("idle_anim_clr", int'(anim_frame), 0);

        // Blocked step.
        do_reset();
        run_frames(3, 8'h07, 1'b0);
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 8'h07, 1'b1, 1'b1);
        check_eq("blocked_bump", int'(bump), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("blocked_bump_end", int'(bump), 0);
        check_eq("blocked_tile_x", int'(tile_x), 10);

        // Walk to the left edge, then push against it.
        do_reset();
        run_frames(200, 8'h04, 1'b0);
        check_eq("edge_tile_x", int'(tile_x), 0);
        cyc(1'b1, 8'h04, 1'b0, 1'b0);
        check_eq("edge_bump", int'(bump), 1);
        check_eq("edge_no_req", int'(bif.blk_req), 0);
        cyc(1'b0, 8'h04, 1'b0, 1'b0);
        check_eq("edge_pos_x", int'(pos_x), 0);

        // Key released halfway through a step.
        do_reset();
        run_frames(3, 8'h07, 1'b0);
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 8'h07, 1'b1, 1'b0);
        run_frames(8, 8'h07, 1'b0);
        check_eq("mid_pos_x", int'(pos_x), 168);
        run_frames(8, 8'h00, 1'b0);
        check_eq("release_tile_x", int'(tile_x), 11);
        run_frames(1, 8'h00, 1'b0);
        check_eq("release_anim", int'(anim_frame), 0);

        // Reset while a query is outstanding.
        do_reset();
        run_frames(3, 8'h07, 1'b0);
        cyc(1'b1, 8'h07, 1'b0, 1'b0);
        check_eq("pre_reset_req", int'(bif.blk_req), 1);
        do_reset();
        check_eq("reset_tile_x", int'(tile_x), 10);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("stale_ack_bump", int'(bump), 0);
        check_eq("stale_ack_moving", int'(moving), 0);

        // Randomised traffic, including spurious acks and tick/ack collisions.
        cur_key = 8'h00;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_key = keys[$urandom_range(0, 5)];
            r_tick = ($urandom_range(0, 2) == 0);
            r_ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            r_blk  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc(r_tick, cur_key, r_ack, r_blk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
